alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-driven controller that sequences the 4-entry register bank and the 2-bit-op ALU. It replaces direct switch control of the bank addresses, the write enable and the ALU select. Commands (ALU op or 4-bit immediate load) enter a small FIFO through a valid/ready handshake, then execute in order. Each command runs as an EXEC cycle (operand read, ALU evaluate, result/flag capture) followed by a WB cycle (register write). Sits between the keypad/switch front end and the REG/ALU datapath inside the top-level tile.

## Interface
- WIDTH, 8, datapath width (register/ALU data)
- DEPTH, 4, command FIFO depth; power of 2, ≥2
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; derived at top level as !rst_n
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; = !full
- cmd_op  in  2  ALU select for ALU commands
- cmd_src  in  1  0 = ALU result, 1 = immediate load
- cmd_ra / cmd_rb / cmd_rd  in  2 each  operand A, operand B, destination register
- cmd_imm  in  4  immediate (keypad code), zero-extended to WIDTH
- halt  in  1  when high, no new command is popped; the current command completes
- rf_addr_a / rf_addr_b / rf_addr_wr  out  2 each  to bank DIR_A / DIR_B / DIR_WR
- rf_wr_en  out  1  bank write enable
- rf_wr_data  out  WIDTH  bank write data
- rf_doa / rf_dob  in  WIDTH  bank read data (combinational read)
- alu_sel  out  2  ALU op select
- alu_out  in  WIDTH; alu_carry, alu_zero  in  1  ALU results (combinational)
- result  out  WIDTH  last captured result
- carry_flag / zero_flag  out  1  flags from the last ALU command
- done  out  1  one-cycle pulse during the WB cycle
- busy  out  1  high in EXEC or WB
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- FIFO: push when cmd_valid && cmd_ready. Pop only in IDLE or WB, and only when non-empty && !halt. Simultaneous push and pop are both honoured; count is unchanged. No bypass: a command pushed into an empty FIFO is poppable the next cycle.
- Popped fields are loaded into the current-command register (cur_*).
- States:
  - IDLE: on pop, go to EXEC.
  - EXEC: rf_addr_a=cur_ra, rf_addr_b=cur_rb, alu_sel=cur_op. At the end of the cycle:
    - ALU command: result←alu_out, carry_flag←alu_carry, zero_flag←alu_zero.
    - Immediate command: result←{0,cur_imm}; flags unchanged.
    - Next state is WB.
  - WB: rf_wr_en=1, rf_addr_wr=cur_rd, rf_wr_data=result, done=1. If a pop occurs, go to EXEC; otherwise go to IDLE.
- Outside EXEC, rf_addr_a/b and alu_sel hold their last values. rf_wr_en=0 outside WB.
- Read-after-write: the bank write commits at the end of WB, so the following EXEC reads the updated value. No forwarding or stall is needed.
- halt sampled high in WB: finish WB, go to IDLE, and keep the FIFO contents.
- Reset (any state, including mid-command): state←IDLE, FIFO emptied, fifo_count=0. result, carry_flag, zero_flag, rf_* outputs, alu_sel, done and busy all ←0. An in-flight WB is dropped with no write. cmd_ready is 0 while reset is high and 1 in the first cycle after.

## Timing
- Command accepted at edge k, FIFO previously empty:
  - popped at edge k+1;
  - EXEC during cycle k+1→k+2;
  - WB/done during k+2→k+3;
  - bank write at edge k+3.
- Latency from accept to done is 2 cycles after the accept edge.
- Sustained throughput is 1 command per 2 cycles (EXEC, WB, EXEC, ...).
- Full FIFO: cmd_ready=0. A pop in WB raises cmd_ready in the next cycle. cmd_ready never depends combinationally on pop.
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

## Test plan
- Reset/idle: hold reset 2 cycles, then release. All outputs must be 0, except cmd_ready, which must be 1 after release. No rf_wr_en for 10 idle cycles.
- Immediate then add (bench ALU model: op 00 = A+B):
  - push imm 4'h5→r1 and imm 4'h3→r2 back-to-back, then ALU op 00, ra=r1, rb=r2, rd=r3;
  - required: three done pulses 2 cycles apart;
  - r3 = 8'h08; result = 8'h08; carry_flag=0, zero_flag=0.
- Carry/zero: load r0=8'hF0 (preset via bank) and r1=8'h10, then execute op 00 → result 8'h00, carry_flag=1, zero_flag=1.
- FIFO full with halt=1:
  - push 5 commands with DEPTH=4: cmd_ready=0 after the 4th push, fifo_count=4, 5th not accepted;
  - release halt: exactly 4 done pulses in order, with destination registers matching the push order.
- Simultaneous push/pop: stream 8 commands with cmd_valid held high. fifo_count stays ≤DEPTH, no command is lost or duplicated, and writes match a reference scoreboard.
- Reset mid-command: assert reset during EXEC of a load to r2. r2 is unchanged, done is never asserted, and the FIFO is empty after reset.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command FIFO feeding an in-order EXEC/WB controller that drives the
// register bank addresses, its write port and the ALU select.
module alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic                   cmd_src,
  input  logic [1:0]             cmd_ra,
  input  logic [1:0]             cmd_rb,
  input  logic [1:0]             cmd_rd,
  input  logic [3:0]             cmd_imm,
  input  logic                   halt,
  output logic [1:0]             rf_addr_a,
  output logic [1:0]             rf_addr_b,
  output logic [1:0]             rf_addr_wr,
  output logic                   rf_wr_en,
  output logic [WIDTH-1:0]       rf_wr_data,
  input  logic [WIDTH-1:0]       rf_doa,
  input  logic [WIDTH-1:0]       rf_dob,
  output logic [1:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  output logic [WIDTH-1:0]       result,
  output logic                   carry_flag,
  output logic                   zero_flag,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic       src;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rd;
    logic [3:0] imm;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e            state_q, state_d;
  cmd_t              mem_q [DEPTH];
  cmd_t              cmd_in;
  cmd_t              cur_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic [WIDTH-1:0]  result_q;
  logic              carry_q, zero_q;
  logic              full, empty, push, pop;

  // Operand data goes straight from the bank to the ALU; only ALU results come back here.
  logic unused_rd_data;
  assign unused_rd_data = ^{rf_doa, rf_dob};

  assign cmd_in = '{op: cmd_op, src: cmd_src, ra: cmd_ra, rb: cmd_rb, rd: cmd_rd, imm: cmd_imm};

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = ((state_q == StIdle) || (state_q == StWb)) && !empty && !halt && !reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = pop ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        cur_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else if (state_q == StExec) begin
      if (cur_q.src) begin
        result_q <= {{(WIDTH - 4){1'b0}}, cur_q.imm};
      end else begin
        result_q <= alu_out;
        carry_q  <= alu_carry;
        zero_q   <= alu_zero;
      end
    end
  end

  // cur_q only changes on a pop, which always enters EXEC, so driving the addresses and
  // select straight from it gives the hold-last-value behaviour outside EXEC.
  assign rf_addr_a  = cur_q.ra;
  assign rf_addr_b  = cur_q.rb;
  assign alu_sel    = cur_q.op;
  assign rf_addr_wr = cur_q.rd;
  assign rf_wr_data = result_q;

  // Gated by reset so a WB interrupted by reset never commits to the bank.
  assign rf_wr_en   = (state_q == StWb) && !reset;
  assign done       = (state_q == StWb) && !reset;
  assign busy       = (state_q != StIdle) && !reset;

  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign fifo_count = count_q;

  count_bound_a: assert property (@(posedge clk) disable iff (reset) count_q <= FullCount);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: bank/ALU environment, table-driven vectors, directed corner
// sequences and a randomized phase checked against a command-level scoreboard.
module tb_alu_sequencer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, cmd_valid, cmd_ready, cmd_src, halt;
  logic [1:0]       cmd_op, cmd_ra, cmd_rb, cmd_rd;
  logic [3:0]       cmd_imm;
  logic [1:0]       rf_addr_a, rf_addr_b, rf_addr_wr, alu_sel;
  logic             rf_wr_en, alu_carry, alu_zero, carry_flag, zero_flag, done, busy;
  logic [WIDTH-1:0] rf_wr_data, rf_doa, rf_dob, alu_out, result;
  logic [CntW-1:0]  fifo_count;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .halt(halt), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_addr_wr(rf_addr_wr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_doa(rf_doa), .rf_dob(rf_dob), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .result(result), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .done(done), .busy(busy), .fifo_count(fifo_count)
  );

  // Datapath environment: 4-entry bank with combinational read, plus the 2-bit-op ALU.
  logic [7:0] bank [4];
  logic       preset_en;
  logic [1:0] preset_addr;
  logic [7:0] preset_data;

  always @(posedge clk) begin
    if (rf_wr_en) bank[rf_addr_wr] <= rf_wr_data;
    else if (preset_en) bank[preset_addr] <= preset_data;
  end

  assign rf_doa = bank[rf_addr_a];
  assign rf_dob = bank[rf_addr_b];

  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      2'b00:   {alu_carry, alu_out} = {1'b0, rf_doa} + {1'b0, rf_dob};
      2'b01: begin
        alu_out   = rf_doa - rf_dob;
        alu_carry = rf_doa < rf_dob;
      end
      2'b10:   alu_out = rf_doa & rf_dob;
      default: alu_out = rf_doa ^ rf_dob;
    endcase
    alu_zero = (alu_out == '0);
  end

  // Reference model: ordered list of accepted commands, architectural registers and flags.
  typedef struct {
    bit       src;
    bit [1:0] op, ra, rb, rd;
    bit [3:0] imm;
  } cmd_s;

  cmd_s exp_q[$];
  int   ref_regs [4] = '{default: 0};
  bit   ref_c, ref_z;
  int   done_cyc[$];
  int   done_rd[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output bit c);
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = a < b; end
      2: begin r = a & b; c = 1'b0; end
      default: begin r = a ^ b; c = 1'b0; end
    endcase
  endfunction

  // Runs once per cycle between edges: scores a WB, then records what the next edge commits.
  task automatic monitor();
    cmd_s c;
    int   r;
    bit   cy;
    if (reset) begin
      exp_q.delete();
      ref_c = 1'b0;
      ref_z = 1'b0;
      return;
    end
    check("fifo_count_le_depth", int'(fifo_count <= CntW'(DEPTH)), 1);
    if (done) begin
      check("done_has_pending_cmd", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        if (c.src) begin
          r = int'(c.imm);
        end else begin
          ref_alu(int'(c.op), ref_regs[c.ra], ref_regs[c.rb], r, cy);
          ref_c = cy;
          ref_z = (r == 0);
        end
        check("wb_wr_en", int'(rf_wr_en), 1);
        check("wb_addr", int'(rf_addr_wr), int'(c.rd));
        check("wb_data", int'(rf_wr_data), r);
        check("wb_result", int'(result), r);
        check("wb_carry_flag", int'(carry_flag), int'(ref_c));
        check("wb_zero_flag", int'(zero_flag), int'(ref_z));
        ref_regs[c.rd] = r;
        done_cyc.push_back(cyc);
        done_rd.push_back(int'(c.rd));
      end
    end
    if (preset_en) ref_regs[preset_addr] = int'(preset_data);
    if (cmd_valid && cmd_ready)
      exp_q.push_back('{src: cmd_src, op: cmd_op, ra: cmd_ra, rb: cmd_rb, rd: cmd_rd,
                        imm: cmd_imm});
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preset(input bit [1:0] a, input bit [7:0] d);
    preset_en   = 1'b1;
    preset_addr = a;
    preset_data = d;
    step();
    preset_en   = 1'b0;
  endtask

  task automatic push_cmd(input bit src, input bit [1:0] op, input bit [1:0] ra,
                          input bit [1:0] rb, input bit [1:0] rd, input bit [3:0] imm);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_op    = op;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_rd    = rd;
    cmd_imm   = imm;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (!cmd_ready) check("push_timeout", 0, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || fifo_count != '0) && n < 500) begin
      step();
      n++;
    end
    check("drain_timeout", int'(busy || fifo_count != '0), 0);
  endtask

  typedef struct {
    bit       src;
    bit [1:0] op;
    bit [7:0] a, b;
    bit [3:0] imm;
    bit [7:0] exp_r;
    bit       exp_c, exp_z;
  } vec_s;

  vec_s vecs[11];
  int   n0, t0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Immediate rows must leave the flags as the preceding ALU row set them.
    vecs[0]  = '{1'b0, 2'b00, 8'h05, 8'h03, 4'h0, 8'h08, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 8'hF0, 8'h10, 4'h0, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 2'b00, 8'h00, 8'h00, 4'hC, 8'h0C, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 2'b00, 8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 8'h10, 8'h01, 4'h0, 8'h0F, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 8'h01, 8'h02, 4'h0, 8'hFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 8'h33, 8'h33, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 8'h00, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'b10, 8'hF0, 8'h0F, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 2'b11, 8'hAA, 8'h0F, 4'h0, 8'hA5, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 8'h00, 8'h00, 4'hF, 8'h0F, 1'b0, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; halt = 1'b0; preset_en = 1'b0;
    cmd_src = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_imm = '0;
    preset_addr = '0; preset_data = '0;

    // Reset and idle behaviour
    step();
    check("ready_during_reset", int'(cmd_ready), 0);
    step();
    reset = 1'b0;
    #1;
    check("ready_after_reset", int'(cmd_ready), 1);
    check("reset_result", int'(result), 0);
    check("reset_carry", int'(carry_flag), 0);
    check("reset_zero", int'(zero_flag), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_fifo_count", int'(fifo_count), 0);
    check("reset_alu_sel", int'(alu_sel), 0);
    check("reset_addrs", int'({rf_addr_a, rf_addr_b, rf_addr_wr}), 0);
    check("reset_wr_data", int'(rf_wr_data), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_no_write", int'(rf_wr_en), 0);
    end
    for (int i = 0; i < 4; i++) preset(2'(i), 8'h00);

    // Immediate loads then add, back to back
    n0 = done_cyc.size();
    push_cmd(1'b1, 2'b00, 2'd0, 2'd0, 2'd1, 4'h5);
    t0 = cyc;
    push_cmd(1'b1, 2'b00, 2'd0, 2'd0, 2'd2, 4'h3);
    push_cmd(1'b0, 2'b00, 2'd1, 2'd2, 2'd3, 4'h0);
    wait_idle();
    check("add_done_count", done_cyc.size() - n0, 3);
    if (done_cyc.size() - n0 >= 3) begin
      check("add_first_latency", done_cyc[n0] - t0, 2);
      check("add_done_gap1", done_cyc[n0 + 1] - done_cyc[n0], 2);
      check("add_done_gap2", done_cyc[n0 + 2] - done_cyc[n0 + 1], 2);
    end
    check("add_r3", int'(bank[3]), 'h08);
    check("add_result", int'(result), 'h08);
    check("add_carry", int'(carry_flag), 0);
    check("add_zero", int'(zero_flag), 0);

    // Table-driven ALU and immediate vectors
    for (int i = 0; i < 11; i++) begin
      if (!vecs[i].src) begin
        preset(2'd0, vecs[i].a);
        preset(2'd1, vecs[i].b);
      end
      push_cmd(vecs[i].src, vecs[i].op, 2'd0, 2'd1, 2'd2, vecs[i].imm);
      wait_idle();
      check("vec_result", int'(result), int'(vecs[i].exp_r));
      check("vec_carry", int'(carry_flag), int'(vecs[i].exp_c));
      check("vec_zero", int'(zero_flag), int'(vecs[i].exp_z));
      check("vec_bank_r2", int'(bank[2]), int'(vecs[i].exp_r));
    end

    // FIFO full under halt, then halt raised again during a WB
    halt = 1'b1;
    n0 = done_rd.size();
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 2'b00, 2'd0, 2'd0, 2'(i), 4'(i + 1));
    check("full_ready", int'(cmd_ready), 0);
    check("full_count", int'(fifo_count), 4);
    cmd_valid = 1'b1; cmd_src = 1'b1; cmd_rd = 2'd0; cmd_imm = 4'hF;
    repeat (3) step();
    cmd_valid = 1'b0;
    check("fifth_rejected_count", int'(fifo_count), 4);
    check("fifth_rejected_ready", int'(cmd_ready), 0);
    halt = 1'b0;
    step();
    check("ready_after_pop", int'(cmd_ready), 1);
    check("count_after_pop", int'(fifo_count), 3);
    step();
    check("first_wb_done", int'(done), 1);
    halt = 1'b1;
    step();
    check("halt_in_wb_idle", int'(busy), 0);
    check("halt_in_wb_keeps_fifo", int'(fifo_count), 3);
    repeat (3) step();
    check("halt_holds_fifo", int'(fifo_count), 3);
    halt = 1'b0;
    wait_idle();
    check("full_done_count", done_rd.size() - n0, 4);
    if (done_rd.size() - n0 >= 4)
      for (int i = 0; i < 4; i++) check("full_order_rd", done_rd[n0 + i], i);
    for (int i = 0; i < 4; i++) check("full_bank", int'(bank[i]), i + 1);

    // Streaming with cmd_valid held high
    n0 = done_rd.size();
    for (int i = 0; i < 8; i++)
      push_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    wait_idle();
    check("stream_done_count", done_rd.size() - n0, 8);

    // Randomized traffic with sporadic halt
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_src   = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_ra    = 2'($urandom_range(0, 3));
      cmd_rb    = 2'($urandom_range(0, 3));
      cmd_rd    = 2'($urandom_range(0, 3));
      cmd_imm   = 4'($urandom_range(0, 15));
      halt      = ($urandom_range(0, 7) == 0);
      step();
    end
    cmd_valid = 1'b0;
    halt = 1'b0;
    wait_idle();
    check("random_scoreboard_drained", exp_q.size(), 0);

    // Reset during EXEC of an immediate load to r2
    preset(2'd2, 8'h77);
    n0 = done_cyc.size();
    push_cmd(1'b1, 2'b00, 2'd0, 2'd0, 2'd2, 4'h9);
    step();
    check("midcmd_in_exec", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("midcmd_ready_in_reset", int'(cmd_ready), 0);
    step();
    reset = 1'b0;
    repeat (5) step();
    check("midcmd_r2_unchanged", int'(bank[2]), 'h77);
    check("midcmd_no_done", done_cyc.size() - n0, 0);
    check("midcmd_fifo_empty", int'(fifo_count), 0);
    check("midcmd_idle", int'(busy), 0);
    check("midcmd_result_cleared", int'(result), 0);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
